// File: rtl/subblock_serializer.sv
// Serializes three encoder subblocks as interleaved bytes over a valid/ready stream.
// Optional trailing XOR parity byte when SERIALIZER_PARITY_EN is defined.
module subblock_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       computation_done,
    input  logic [7:0] blk_len,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    output logic [2:0] rdreq_subblock,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned KW = 2;
    localparam int unsigned NSUB = 3;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {IDLE, REQ, CAPT, OUT, PAR, DONE} state_t;
    logic [DW-1:0] par_acc;
`else
    typedef enum logic [2:0] {IDLE, REQ, CAPT, OUT, DONE} state_t;
`endif

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_i;
    logic [KW-1:0] idx_k;
    logic [KW-1:0] next_k_c;
    logic          final_byte_c;
    logic [DW-1:0] q_sel_c;

    assign final_byte_c = (idx_i == len_q - LW'(1)) && (idx_k == KW'(NSUB - 1));
    assign next_k_c     = (idx_k == KW'(NSUB - 1)) ? KW'(0) : idx_k + KW'(1);

    // Read data of the subblock requested last cycle
    always_comb begin
        q_sel_c = q0;
        case (idx_k)
            2'd1:    q_sel_c = q1;
            2'd2:    q_sel_c = q2;
            default: q_sel_c = q0;
        endcase
    end

    // Control FSM with registered outputs; rdreq is loaded on entry to REQ so it is high only there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            len_q          <= '0;
            idx_i          <= '0;
            idx_k          <= '0;
            rdreq_subblock <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_acc        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (computation_done) begin
                        busy <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
                        par_acc <= '0;
`endif
                        if (blk_len != LW'(0)) begin
                            len_q          <= blk_len;
                            idx_i          <= '0;
                            idx_k          <= '0;
                            rdreq_subblock <= 3'b001;
                            state          <= REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    rdreq_subblock <= '0;
                    state          <= CAPT;
                end
                CAPT: begin
                    out_data  <= q_sel_c;
                    out_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= final_byte_c;
`endif
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
                        par_acc   <= par_acc ^ out_data;
`endif
                        if (final_byte_c) begin
`ifdef SERIALIZER_PARITY_EN
                            state <= PAR;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            idx_k          <= next_k_c;
                            idx_i          <= (idx_k == KW'(NSUB - 1)) ? idx_i + LW'(1) : idx_i;
                            rdreq_subblock <= 3'(3'b001 << next_k_c);
                            state          <= REQ;
                        end
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                // First cycle presents the accumulator, then waits for the handshake
                PAR: begin
                    if (!out_valid) begin
                        out_data  <= par_acc;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subblock_serializer.sv
// Self-checking bench for subblock_serializer: vector table plus reset and parity sequences.
module tb_subblock_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR_EXTRA = 1;
`else
    localparam int PAR_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       computation_done;
    logic [7:0] blk_len;
    logic [7:0] q0, q1, q2;
    logic [2:0] rdreq_subblock;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    subblock_serializer dut (
        .clk              (clk),
        .reset            (reset),
        .computation_done (computation_done),
        .blk_len          (blk_len),
        .q0               (q0),
        .q1               (q1),
        .q2               (q2),
        .rdreq_subblock   (rdreq_subblock),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        int         len;
        logic [7:0] seed;
        int         stall_at;
        int         stall_n;
        bit         second;
        int         exp_bytes;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [3][256];
    logic [7:0] ptr [3];
    logic [7:0] qa  [3];
    logic [2:0] rd_seen;
    logic       ptr_clr;
    int         n_chk = 0;
    int         n_pass = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    int         acc_cnt = 0;
    int         exp_k = 0;
    logic [7:0] last_byte;
    logic [7:0] prev_data;
    bit         prev_hold = 0;

    assign q0 = qa[0];
    assign q1 = qa[1];
    assign q2 = qa[2];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Encoder model: data appears one cycle after the request cycle
    always @(posedge clk) begin
        if (ptr_clr) begin
            for (int k = 0; k < 3; k++) ptr[k] <= 8'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rd_seen[k]) begin
                    qa[k]  <= mem[k][ptr[k]];
                    ptr[k] <= ptr[k] + 8'd1;
                end
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        rd_seen <= rdreq_subblock;
        if (!reset) begin
            exp_k     = 0;
            prev_hold = 0;
        end else begin
            if (rdreq_subblock != 3'd0) begin
                rd_cnt++;
                check("rdreq_order", int'(rdreq_subblock), 1 << exp_k);
                check("rdreq_during_valid", int'(out_valid), 0);
                exp_k = (exp_k == 2) ? 0 : exp_k + 1;
            end
            if (out_last && !out_valid) check("last_without_valid", 1, 0);
            if (out_valid) begin
                if (prev_hold) check("hold_data", int'(out_data), int'(prev_data));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_byte", int'(out_data), -1);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", int'(out_data), int'(e.data));
                        check("out_last", int'(out_last), int'(e.last));
                    end
                    acc_cnt++;
                    last_byte = out_data;
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    prev_data = out_data;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic fill_mem(input logic [7:0] seed);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 256; j++)
                mem[k][j] = 8'(10 * (k + 1) + j + 1) ^ seed;
    endtask

    task automatic push_expected(input int len);
        exp_t       e;
        logic [7:0] par;
        par = 8'd0;
        for (int j = 0; j < len; j++) begin
            for (int k = 0; k < 3; k++) begin
                e.data = mem[k][j];
                e.last = (PAR_EXTRA == 0) && (j == len - 1) && (k == 2);
                par    = par ^ e.data;
                sb.push_back(e);
            end
        end
        if (PAR_EXTRA != 0 && len > 0) begin
            e.data = par;
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic clear_ptrs();
        @(posedge clk); #1 ptr_clr = 1'b1;
        @(posedge clk); #1 ptr_clr = 1'b0;
    endtask

    task automatic run_block(input vec_t v, input bit keep_mem);
        int d0, cyc, stall_left;
        bit stalled;
        if (!keep_mem) fill_mem(v.seed);
        push_expected(v.len);
        clear_ptrs();
        acc_cnt    = 0;
        rd_cnt     = 0;
        d0         = done_cnt;
        stalled    = 0;
        stall_left = 0;
        computation_done = 1'b1;
        blk_len          = 8'(v.len);
        @(posedge clk); #1;
        computation_done = 1'b0;
        blk_len          = 8'hFF;
        cyc = 1;
        if (v.second) begin
            repeat (3) @(posedge clk);
            #1 check("busy_before_second", int'(busy), 1);
            computation_done = 1'b1;
            blk_len          = 8'd7;
            @(posedge clk); #1 computation_done = 1'b0;
            cyc += 4;
        end
        while (done_cnt == d0 && cyc < 5000) begin
            if (!stalled && v.stall_at >= 0 && out_valid && acc_cnt == v.stall_at) begin
                out_ready  = 1'b0;
                stall_left = v.stall_n;
                stalled    = 1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        if (cyc >= 5000) check("done_timeout", 0, 1);
        if (v.len == 0) check("zero_len_done_latency_ok", int'(cyc <= 2), 1);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        repeat (10) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("bytes_emitted", acc_cnt, v.exp_bytes + ((v.len > 0) ? PAR_EXTRA : 0));
        check("rdreq_pulses", rd_cnt, 3 * v.len);
        check("scoreboard_empty", sb.size(), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(out_valid), 0);
    endtask

    vec_t vt[6];

    initial begin
        int cyc;
        vec_t v;
        vt[0] = '{len: 2, seed: 8'h00, stall_at: -1, stall_n: 0, second: 0, exp_bytes: 6};
        vt[1] = '{len: 2, seed: 8'h00, stall_at:  1, stall_n: 5, second: 0, exp_bytes: 6};
        vt[2] = '{len: 0, seed: 8'h00, stall_at: -1, stall_n: 0, second: 0, exp_bytes: 0};
        vt[3] = '{len: 3, seed: 8'h5A, stall_at: -1, stall_n: 0, second: 1, exp_bytes: 9};
        vt[4] = '{len: 5, seed: 8'h33, stall_at:  4, stall_n: 2, second: 0, exp_bytes: 15};
        vt[5] = '{len: 1, seed: 8'hC3, stall_at:  0, stall_n: 3, second: 0, exp_bytes: 3};

        reset            = 1'b0;
        computation_done = 1'b0;
        blk_len          = 8'd0;
        out_ready        = 1'b1;
        ptr_clr          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdreq", int'(rdreq_subblock), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset   = 1'b1;
        ptr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) run_block(vt[t], 1'b0);

        // Reset while the third byte of a four-byte-deep block is presented
        fill_mem(8'h00);
        push_expected(4);
        clear_ptrs();
        acc_cnt          = 0;
        computation_done = 1'b1;
        blk_len          = 8'd4;
        @(posedge clk); #1 computation_done = 1'b0;
        cyc = 0;
        while (!(out_valid && acc_cnt == 2) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 200) check("reset_test_timeout", 0, 1);
        reset = 1'b0;
        #1;
        check("midrst_rdreq", int'(rdreq_subblock), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_last", int'(out_last), 0);
        check("midrst_data", int'(out_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        sb.delete();
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("post_rst_stays_idle", int'(busy), 0);
        v = '{len: 1, seed: 8'h00, stall_at: -1, stall_n: 0, second: 0, exp_bytes: 3};
        run_block(v, 1'b0);

`ifdef SERIALIZER_PARITY_EN
        mem[0][0] = 8'h0F;
        mem[1][0] = 8'hF0;
        mem[2][0] = 8'h55;
        v = '{len: 1, seed: 8'h00, stall_at: -1, stall_n: 0, second: 0, exp_bytes: 3};
        run_block(v, 1'b1);
        check("parity_byte", int'(last_byte), 8'hAA);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
